// File: rtl/phase_timer_if.sv
// Signal bundle between a phase_timer and whatever drives it.
// The master drives the controls and threshold writes; the slave returns the phase flags.
interface phase_timer_if #(
  parameter int WIDTH = 8
);
  logic             sc;
  logic             en;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [WIDTH-1:0] cfg_data;
  logic             ts;
  logic             tm;
  logic             tl;
  logic             busy;
  logic             fb;

  modport master (
    output sc, en, cfg_we, cfg_sel, cfg_data,
    input  ts, tm, tl, busy, fb
  );

  modport slave (
    input  sc, en, cfg_we, cfg_sel, cfg_data,
    output ts, tm, tl, busy, fb
  );
endinterface

// File: rtl/phase_timer.sv
// Saturating phase counter with three programmable thresholds.
// Flags are either levels or one-cycle arrival pulses, chosen by PULSE.
module phase_timer #(
  parameter int WIDTH     = 8,
  parameter int SHORT_DEF = 2,
  parameter int MID_DEF   = 5,
  parameter int LONG_DEF  = 29,
  parameter bit PULSE     = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  phase_timer_if.slave bus
);

  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] thr_s_q, thr_s_d;
  logic [WIDTH-1:0] thr_m_q, thr_m_d;
  logic [WIDTH-1:0] thr_l_q, thr_l_d;
  logic             fresh_q, fresh_d;
  logic             fb_q, fb_d;

  // Counting stops at the limit; a limit lowered below t leaves t where it is.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] val,
                                               input logic [WIDTH-1:0] lim);
    return (val < lim) ? val + 1'b1 : val;
  endfunction

  always_comb begin
    t_d     = t_q;
    fresh_d = 1'b0;
    thr_s_d = thr_s_q;
    thr_m_d = thr_m_q;
    thr_l_d = thr_l_q;
    fb_d    = bus.sc;

    if (bus.sc) begin
      t_d     = '0;
      fresh_d = 1'b1;
    end else if (bus.en && (t_q < thr_l_q)) begin
      t_d     = sat_inc(t_q, thr_l_q);
      fresh_d = 1'b1;
    end

    if (bus.cfg_we) begin
      case (bus.cfg_sel)
        2'd0:    thr_s_d = bus.cfg_data;
        2'd1:    thr_m_d = bus.cfg_data;
        2'd2:    thr_l_d = bus.cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= '0;
      fresh_q <= 1'b0;
      fb_q    <= 1'b0;
      thr_s_q <= WIDTH'(SHORT_DEF);
      thr_m_q <= WIDTH'(MID_DEF);
      thr_l_q <= WIDTH'(LONG_DEF);
    end else begin
      t_q     <= t_d;
      fresh_q <= fresh_d;
      fb_q    <= fb_d;
      thr_s_q <= thr_s_d;
      thr_m_q <= thr_m_d;
      thr_l_q <= thr_l_d;
    end
  end

  // Pulse mode: equality alone would repeat while held, so gate with fresh.
  generate
    if (PULSE) begin : g_pulse
      assign bus.ts = fresh_q && (t_q == thr_s_q);
      assign bus.tm = fresh_q && (t_q == thr_m_q);
      assign bus.tl = fresh_q && (t_q == thr_l_q);
    end else begin : g_level
      assign bus.ts = (t_q >= thr_s_q);
      assign bus.tm = (t_q >= thr_m_q);
      assign bus.tl = (t_q >= thr_l_q);
    end
  endgenerate

  assign bus.busy = (t_q < thr_l_q);
  assign bus.fb   = fb_q;

endmodule
